// File: rtl/clock_enable_gen.sv
// Multi-rate clock-enable generator: CPU (run-time selectable rate, wait-stretchable),
// pixel and PSG single-cycle enables, all derived from one master clock domain.
module clock_enable_gen #(
    parameter int unsigned CNT_W     = 4,
    parameter int unsigned CPU_SHIFT = 3,
    parameter int unsigned PIX_SHIFT = 2,
    parameter int unsigned PSG_SHIFT = 4,
    parameter int unsigned MAX_SPEED = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] speed,
    input  logic       cpu_wait,
    output logic       cep_cpu,
    output logic       cen_cpu,
    output logic       ce_pix,
    output logic       ce_psg,
    output logic [1:0] speed_act
);

    typedef logic [CNT_W-1:0]     cnt_t;
    typedef logic [CPU_SHIFT-1:0] cpu_cnt_t;

    localparam cpu_cnt_t   CpuHalf = cpu_cnt_t'(1) << (CPU_SHIFT - 1);
    localparam logic [1:0] MaxSpd  = 2'(MAX_SPEED);

    cnt_t       cnt_q, cnt_d;
    cpu_cnt_t   cpu_cnt_q, cpu_cnt_d;
    logic [1:0] speed_act_d;
    logic [1:0] spd_req;
    logic [1:0] step;
    logic       cep_d, cen_d, pix_d, psg_d;

    always_comb begin
        spd_req     = (speed > MaxSpd) ? MaxSpd : speed;
        cnt_d       = cnt_q + cnt_t'(1);
        pix_d       = (cnt_q[PIX_SHIFT-1:0] == '0);
        psg_d       = (cnt_q[PSG_SHIFT-1:0] == '0);
        cep_d       = 1'b0;
        cen_d       = 1'b0;
        cpu_cnt_d   = cpu_cnt_q;
        speed_act_d = speed_act;
        step        = speed_act;
        // A held phase keeps any due enable pending until wait drops.
        if (!cpu_wait) begin
            cep_d = (cpu_cnt_q == '0);
            cen_d = (cpu_cnt_q == CpuHalf);
            // Rate changes only at the cycle boundary keep cpu_cnt a multiple of the step.
            if (cpu_cnt_q == '0) begin
                speed_act_d = spd_req;
                step        = spd_req;
            end
            cpu_cnt_d = cpu_cnt_q + (cpu_cnt_t'(1) << step);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            cpu_cnt_q <= '0;
            speed_act <= 2'd0;
            cep_cpu   <= 1'b0;
            cen_cpu   <= 1'b0;
            ce_pix    <= 1'b0;
            ce_psg    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            cpu_cnt_q <= cpu_cnt_d;
            speed_act <= speed_act_d;
            cep_cpu   <= cep_d;
            cen_cpu   <= cen_d;
            ce_pix    <= pix_d;
            ce_psg    <= psg_d;
        end
    end

endmodule

// File: tb/tb_clock_enable_gen.sv
// Scoreboard bench for clock_enable_gen: directed scenarios with hand-derived enable
// patterns, then a random speed/wait stress run against a cycle model.
module tb_clock_enable_gen;

    typedef struct {
        logic       cep;
        logic       cen;
        logic       pix;
        logic       psg;
        logic [1:0] sa;
        int         tag;
        int         k;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] speed = 2'd0;
    logic       cpu_wait = 1'b0;
    logic       cep_cpu, cen_cpu, ce_pix, ce_psg;
    logic [1:0] speed_act;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   n_cep = 0, n_cen = 0;
    int   coincide = 0, wide = 0;
    bit   stress_on = 1'b0;

    // Cycle model state (stress phase only)
    logic [3:0] m_cnt = '0;
    logic [2:0] m_cpu = '0;
    logic [1:0] m_sa  = '0;

    clock_enable_gen dut (
        .clock    (clock),
        .reset    (reset),
        .speed    (speed),
        .cpu_wait (cpu_wait),
        .cep_cpu  (cep_cpu),
        .cen_cpu  (cen_cpu),
        .ce_pix   (ce_pix),
        .ce_psg   (ce_psg),
        .speed_act(speed_act)
    );

    always #5 clock = ~clock;

    function automatic string tag_name(input int t);
        case (t)
            0: return "reset_hold";
            1: return "speed0_run";
            2: return "switch_0_to_2";
            3: return "speed3_clamp";
            4: return "wait_defer";
            5: return "speed1_pre_reset";
            6: return "restart_after_reset";
            7: return "stress";
            default: return "unknown";
        endcase
    endfunction

    function automatic exp_t mk(input logic cep, input logic cen, input logic pix,
                                input logic psg, input logic [1:0] sa, input int tag,
                                input int k);
        exp_t e;
        e.cep = cep; e.cen = cen; e.pix = pix; e.psg = psg; e.sa = sa;
        e.tag = tag; e.k = k;
        return e;
    endfunction

    task automatic drive(input logic rst, input logic [1:0] spd, input logic w, input exp_t e);
        @(negedge clock);
        reset    = rst;
        speed    = spd;
        cpu_wait = w;
        q.push_back(e);
    endtask

    task automatic reset_cycles(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 2'd0, 1'b0, mk(0, 0, 0, 0, 2'd0, 0, i));
        m_cnt = '0;
        m_cpu = '0;
        m_sa  = '0;
    endtask

    // Spec-level model of one edge with reset released.
    task automatic model_step(input logic [1:0] spd, input logic w, input int k);
        exp_t       e;
        logic [1:0] req, st;
        e = mk(0, 0, (m_cnt[1:0] == 2'd0), (m_cnt == 4'd0), 2'd0, 7, k);
        m_cnt = m_cnt + 4'd1;
        req = (spd > 2'd2) ? 2'd2 : spd;
        if (!w) begin
            e.cep = (m_cpu == 3'd0);
            e.cen = (m_cpu == 3'd4);
            if (m_cpu == 3'd0) begin
                m_sa = req;
                st   = req;
            end else begin
                st = m_sa;
            end
            m_cpu = m_cpu + (3'd1 << st);
        end
        e.sa = m_sa;
        drive(1'b1, spd, w, e);
    endtask

    // Monitor: pops one expectation per clock edge and tracks pulse properties.
    initial begin : monitor
        exp_t       e;
        logic [5:0] got, want;
        logic       p_cep = 0, p_cen = 0, p_pix = 0, p_psg = 0;
        forever begin
            @(posedge clock);
            #1;
            if (reset) begin
                if (cep_cpu && cen_cpu) coincide++;
                if ((cep_cpu && p_cep) || (cen_cpu && p_cen) || (ce_pix && p_pix) ||
                    (ce_psg && p_psg)) wide++;
                if (stress_on && cep_cpu) n_cep++;
                if (stress_on && cen_cpu) n_cen++;
            end
            p_cep = cep_cpu; p_cen = cen_cpu; p_pix = ce_pix; p_psg = ce_psg;
            if (q.size() > 0) begin
                e    = q.pop_front();
                got  = {cep_cpu, cen_cpu, ce_pix, ce_psg, speed_act};
                want = {e.cep, e.cen, e.pix, e.psg, e.sa};
                n_cmp++;
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL %s edge %0d: cep,cen,pix,psg,speed_act got %b want %b",
                             tag_name(e.tag), e.k, got, want);
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic [32:0] cep_m, cen_m;
        logic [5:0]  now;
        reset_cycles(3);

        // Speed 0 free run.
        for (int k = 1; k <= 64; k++)
            drive(1'b1, 2'd0, 1'b0, mk(k % 8 == 1, k % 8 == 5, k % 4 == 1, k % 16 == 1,
                                       2'd0, 1, k));
        reset_cycles(2);

        // Request speed 2 from edge 3; takes effect at the edge-9 boundary.
        for (int k = 1; k <= 24; k++) begin
            if (k < 9)
                drive(1'b1, (k >= 3) ? 2'd2 : 2'd0, 1'b0,
                      mk(k % 8 == 1, k % 8 == 5, k % 4 == 1, k % 16 == 1, 2'd0, 2, k));
            else
                drive(1'b1, 2'd2, 1'b0,
                      mk(k % 2 == 1, k % 2 == 0, k % 4 == 1, k % 16 == 1, 2'd2, 2, k));
        end
        reset_cycles(2);

        // Out-of-range code clamps to MAX_SPEED.
        for (int k = 1; k <= 16; k++)
            drive(1'b1, 2'd3, 1'b0, mk(k % 2 == 1, k % 2 == 0, k % 4 == 1, k % 16 == 1,
                                       2'd2, 3, k));
        reset_cycles(2);

        // Wait on edges 8..12 holds the phase at 7, so the edge-9 cep lands on edge 14.
        cep_m = '0; cen_m = '0;
        cep_m[1] = 1'b1; cep_m[14] = 1'b1; cep_m[22] = 1'b1; cep_m[30] = 1'b1;
        cen_m[5] = 1'b1; cen_m[18] = 1'b1; cen_m[26] = 1'b1;
        for (int k = 1; k <= 32; k++)
            drive(1'b1, 2'd0, (k >= 8 && k <= 12),
                  mk(cep_m[k], cen_m[k], k % 4 == 1, k % 16 == 1, 2'd0, 4, k));
        reset_cycles(2);

        // Speed 1 then an asynchronous reset mid-period.
        for (int k = 1; k <= 5; k++)
            drive(1'b1, 2'd1, 1'b0, mk(k % 4 == 1, k % 4 == 3, k % 4 == 1, k % 16 == 1,
                                       2'd1, 5, k));
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        now = {cep_cpu, cen_cpu, ce_pix, ce_psg, speed_act};
        n_cmp++;
        if (now !== 6'b0) begin
            n_fail++;
            $display("FAIL async_reset: outputs got %b want 000000", now);
        end
        reset_cycles(2);
        for (int k = 1; k <= 24; k++)
            drive(1'b1, 2'd0, 1'b0, mk(k % 8 == 1, k % 8 == 5, k % 4 == 1, k % 16 == 1,
                                       2'd0, 6, k));
        reset_cycles(2);

        // Random speed/wait stress.
        stress_on = 1'b1;
        for (int k = 1; k <= 10000; k++)
            model_step(2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), k);
        @(posedge clock);
        #2;
        stress_on = 1'b0;

        n_cmp++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: queue holds %0d entries, want 0", q.size());
        end
        n_cmp++;
        if (coincide != 0) begin
            n_fail++;
            $display("FAIL cep_cen_coincide: got %0d cycles, want 0", coincide);
        end
        n_cmp++;
        if (wide != 0) begin
            n_fail++;
            $display("FAIL pulse_width: got %0d multi-cycle pulses, want 0", wide);
        end
        n_cmp++;
        if (n_cep - n_cen > 1 || n_cen - n_cep > 1 || n_cep < 100) begin
            n_fail++;
            $display("FAIL cep_cen_balance: cep %0d cen %0d, want equal within 1 (>=100)",
                     n_cep, n_cen);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
